// File: rtl/reg_bank_write_arbiter_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
//   arb_state_t : arbiter FSM states (IDLE = normal arbitration, CLEAR = bank clear)
//   onehot_dec  : address to one-hot decode, sized for the largest supported bank;
//                 callers size-cast the result down to their own bank size.
package reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    localparam int MAX_AW   = 8;
    localparam int MAX_REGS = 256;

    function automatic logic [MAX_REGS-1:0] onehot_dec(input logic [MAX_AW-1:0] addr);
        logic [MAX_REGS-1:0] dec;
        dec       = '0;
        dec[addr] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/reg_bank_write_arbiter_rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   req     : request vector
//   ptr     : index that has highest priority this cycle (must be < N)
//   en      : when low, no grant is issued
//   gnt     : one-hot0 grant
//   gnt_idx : index of the granted requester (0 when none)
//   gnt_vld : a grant was issued
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] idx_s;

    // Walk the requesters starting at ptr, wrapping modulo N; first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = IW'((int'(ptr) + k) % N);
            if (en && !gnt_vld && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                gnt_idx    = idx_s;
                gnt_vld    = 1'b1;
            end else begin
                gnt_vld = gnt_vld;
            end
        end
    end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter in front of a bank of NREGS registers.
// At most one requester is accepted per cycle; the accepted write is issued on
// the shared bus in the following cycle. A level clr_req starts a bank clear
// that holds reg_rst for CLR_CYCLES cycles while arbitration is blocked.
//   clk       : clock, all logic on posedge
//   rst       : synchronous active-low reset
//   req_valid : per-requester write request
//   req_ready : per-requester accept (combinational, one-hot0)
//   req_addr  : requester i address in [i*AW +: AW]
//   req_data  : requester i data in [i*WIDTH +: WIDTH]
//   clr_req   : request a full-bank clear
//   clr_busy  : clear sequence running
//   reg_load  : one-hot0 load strobe to the registers
//   reg_in    : shared write data bus
//   reg_rst   : clear to all registers
//   wr_err    : one-cycle pulse for an accepted write with addr >= NREGS
module reg_bank_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int NREQ       = 4,
    parameter  int NREGS      = 8,
    parameter  int CLR_CYCLES = 2,
    localparam int AW         = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic [NREGS-1:0]      reg_load,
    output logic [WIDTH-1:0]      reg_in,
    output logic                  reg_rst,
    output logic                  wr_err
);

    localparam int            IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int            CW      = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [AW:0]   NREGS_W = (AW + 1)'(NREGS);

    arb_state_t        state_r;
    arb_state_t        next_state_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     next_cnt_s;
    logic [IW-1:0]     rr_ptr_r;
    logic [IW-1:0]     next_ptr_s;

    logic              arb_en_s;
    logic [NREQ-1:0]   gnt_s;
    logic [IW-1:0]     gnt_idx_s;
    logic              gnt_vld_s;

    logic [AW-1:0]     win_addr_s;
    logic [WIDTH-1:0]  win_data_s;
    logic              in_range_s;
    logic [NREGS-1:0]  win_dec_s;

    logic [NREGS-1:0]  reg_load_r;
    logic [WIDTH-1:0]  reg_in_r;
    logic              wr_err_r;

    // Arbitration only in IDLE with no clear requested and reset released.
    assign arb_en_s = rst && (state_r == IDLE) && !clr_req;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_r),
        .en      (arb_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_vld (gnt_vld_s)
    );

    assign req_ready = gnt_s;

    // Select the winning requester's address and data.
    always_comb begin
        win_addr_s = '0;
        win_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                win_addr_s = req_addr[i*AW +: AW];
                win_data_s = req_data[i*WIDTH +: WIDTH];
            end else begin
                win_addr_s = win_addr_s;
            end
        end
    end

    // Out-of-range addresses are consumed but never strobe a register.
    assign in_range_s = ({1'b0, win_addr_s} < NREGS_W);
    assign win_dec_s  = NREGS'(onehot_dec(MAX_AW'(win_addr_s)));

    // Pointer moves to one past the winner; holds when nobody is accepted.
    always_comb begin
        next_ptr_s = rr_ptr_r;
        if (gnt_vld_s) begin
            if (gnt_idx_s == IW'(NREQ - 1)) begin
                next_ptr_s = '0;
            end else begin
                next_ptr_s = gnt_idx_s + IW'(1);
            end
        end else begin
            next_ptr_s = rr_ptr_r;
        end
    end

    // Next-state logic: IDLE enters CLEAR on clr_req; CLEAR counts down to zero.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (clr_req) begin
                    next_state_s = CLEAR;
                    next_cnt_s   = CW'(CLR_CYCLES - 1);
                end else begin
                    next_state_s = IDLE;
                end
            end
            CLEAR: begin
                if (cnt_r == CW'(0)) begin
                    next_state_s = IDLE;
                end else begin
                    next_cnt_s = cnt_r - CW'(1);
                end
            end
            default: begin
                next_state_s = IDLE;
                next_cnt_s   = '0;
            end
        endcase
    end

    // FSM state, clear counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= next_state_s;
            cnt_r    <= next_cnt_s;
            rr_ptr_r <= next_ptr_s;
        end
    end

    // Write stage: the accepted write drives the bus during the next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_load_r <= '0;
            reg_in_r   <= '0;
            wr_err_r   <= 1'b0;
        end else begin
            reg_load_r <= (gnt_vld_s && in_range_s) ? win_dec_s : '0;
            reg_in_r   <= gnt_vld_s ? win_data_s : reg_in_r;
            wr_err_r   <= gnt_vld_s && !in_range_s;
        end
    end

    assign reg_load = reg_load_r;
    assign reg_in   = reg_in_r;
    assign wr_err   = wr_err_r;
    assign reg_rst  = (state_r == CLEAR);
    assign clr_busy = (state_r == CLEAR);

endmodule
